// File: rtl/des_decrypt_iter.sv
// Iterative DES engine: one Feistel round per clock, subkeys regenerated in reverse (K16..K1).
// Define DES_ENC_EN to add the `enc` input, which selects encryption for the accepted block.
module des_decrypt_iter #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DES_ENC_EN
    input  logic        enc,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] c,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] m
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    localparam int CW = $clog2(ROUNDS);

    // Tables use DES numbering: entry value n selects input bit n, bit 1 being the MSB.
    localparam int IP_T [0:63] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                   62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                   57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                   61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [0:63] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                   38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                   36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                   34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [0:47] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                  16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [0:31] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                  2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1_T [0:55] = '{57,49,41,33,25,17,9,1, 58,50,42,34,26,18,10,2,
                                    59,51,43,35,27,19,11,3, 60,52,44,36,63,55,47,39,
                                    31,23,15,7,62,54,46,38, 30,22,14,6,61,53,45,37,
                                    29,21,13,5,28,20,12,4};
    localparam int PC2_T [0:47] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    // Each S-box is 64 nibbles in row-major order (row = b1b6, column = b2..b5), entry 0 at the MSB.
    localparam logic [255:0] SBOX [0:7] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] rh, input logic [47:0] k);
        logic [47:0] x;
        logic [5:0]  six;
        logic [5:0]  idx;
        logic [31:0] s;
        x = perm_e(rh) ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[6'(47 - 6 * b) -: 6];
            idx = {six[5], six[0], six[4:1]};
            s[5'(31 - 4 * b) -: 4] = SBOX[3'(b)][8'(255 - 4 * idx) -: 4];
        end
        return perm_p(s);
    endfunction

    // One Feistel round: rl = xr, rr = xl ^ f(xr, k).
    function automatic logic [63:0] des_round(input logic [31:0] xl, input logic [31:0] xr,
                                              input logic [47:0] k);
        return {xr, xl ^ feistel(xr, k)};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
        case (s)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

`ifdef DES_ENC_EN
    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
        case (s)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction
`endif

    logic [1:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [31:0]   l_reg, r_reg;
    logic [27:0]   c_half_reg, d_half_reg;
    logic [1:0]    sh_dec;
    logic [27:0]   c_rot, d_rot;
    logic [47:0]   subkey;
    logic [63:0]   round_out;

    // PC1(key) is both C0 and C16, so decryption starts unrotated and walks backwards.
    always_comb begin
        sh_dec = 2'd2;
        if (cnt_reg == CW'(0))
            sh_dec = 2'd0;
        else if (cnt_reg == CW'(1) || cnt_reg == CW'(8) || cnt_reg == CW'(15))
            sh_dec = 2'd1;
    end

`ifdef DES_ENC_EN
    logic       enc_reg;
    logic [1:0] sh_enc;
    assign sh_enc = (cnt_reg == CW'(0) || cnt_reg == CW'(1) || cnt_reg == CW'(8) ||
                     cnt_reg == CW'(15)) ? 2'd1 : 2'd2;
    assign c_rot = enc_reg ? rotl28(c_half_reg, sh_enc) : rotr28(c_half_reg, sh_dec);
    assign d_rot = enc_reg ? rotl28(d_half_reg, sh_enc) : rotr28(d_half_reg, sh_dec);
`else
    assign c_rot = rotr28(c_half_reg, sh_dec);
    assign d_rot = rotr28(d_half_reg, sh_dec);
`endif

    assign subkey    = perm_pc2({c_rot, d_rot});
    assign round_out = des_round(l_reg, r_reg, subkey);
    assign in_ready  = (state_reg == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            l_reg      <= '0;
            r_reg      <= '0;
            c_half_reg <= '0;
            d_half_reg <= '0;
            m          <= '0;
            out_valid  <= 1'b0;
`ifdef DES_ENC_EN
            enc_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: if (in_valid) begin
                    {l_reg, r_reg}           <= perm_ip(c);
                    {c_half_reg, d_half_reg} <= perm_pc1(key);
                    cnt_reg                  <= '0;
                    state_reg                <= RUN;
`ifdef DES_ENC_EN
                    enc_reg                  <= enc;
`endif
                end
                RUN: begin
                    c_half_reg     <= c_rot;
                    d_half_reg     <= d_rot;
                    {l_reg, r_reg} <= round_out;
                    cnt_reg        <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(ROUNDS - 1))
                        state_reg <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        m         <= perm_fp({r_reg, l_reg});
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
